contador_buffer: RTL and testbench
==================================

# contador_buffer

Start-triggered cycle counter with an associated bounded run timer. Once `start` is sampled high, the block counts clock cycles on a 4-bit wrapping counter and measures run length on a 5-bit timer that stops at a fixed limit. It sits as a small control/measurement peripheral; outputs are registered and may feed display or monitoring logic directly.

## Interface
- `COUNT_W`, default 4: width of `count`.
- `TIMER_W`, default 5: width of `timer`.
- `TIMER_LIMIT`, default 20: terminal timer value, at most 2^TIMER_W−1.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; clears all state immediately while low.
- `start`  input  1  level-sensitive run request/enable.
- `count`  output  COUNT_W  cycle counter, wraps modulo 2^COUNT_W.
- `timer`  output  TIMER_W  run timer, stops at TIMER_LIMIT.

## Operation
- States:
  - IDLE: outputs hold.
  - RUN: counting while `start`=1, holding while `start`=0.
  - DONE: timer reached limit; outputs frozen.
- Transitions:
  - IDLE→RUN: edge with `start`=1. On that edge `count`←0 and `timer`←0.
  - RUN, `start`=1: each edge `count`←count+1 (wraps 15→0) and `timer`←timer+1.
  - RUN, `start`=0: `count` and `timer` hold; state remains RUN. Counting resumes when `start` returns high.
  - RUN→DONE: on the edge where `timer` becomes TIMER_LIMIT. `count` also increments on that edge.
  - DONE: `count` and `timer` frozen regardless of `start`.
  - DONE→IDLE: edge with `start`=0. Outputs hold their final values.
- Arithmetic: unsigned.
  - `count` wraps silently.
  - `timer` never exceeds TIMER_LIMIT and never wraps.
- Reset:
  - While `reset`=0: state IDLE, `count`=0, `timer`=0, asynchronously and regardless of `clk`.
  - Reset mid-RUN or mid-DONE aborts the run.
  - After `reset` goes high with `start` already high: the first edge performs IDLE→RUN (clear) and counting resumes on the following edges.

## Timing
- All outputs are registered; no combinational path from `start` to outputs.
- Start latency:
  - Edge E0 (`start`=1 sampled in IDLE): outputs 0.
  - Edge E0+n, with continuous `start`: `count`=n mod 16, `timer`=n.
- Terminal point, TIMER_LIMIT=20: at E0+20, `timer`=20 and `count`=4, state DONE. Both frozen from then on.
- Reset release takes effect on the first rising edge after `reset` goes high. No synchroniser is inside the block.

## Structure
- Shared package `contador_buffer_pkg`:
  - state enum `cb_state_t` {IDLE, RUN, DONE};
  - default constants `CB_COUNT_W`=4, `CB_TIMER_W`=5, `CB_TIMER_LIMIT`=20.
- One sub-module is natural: `cb_up_counter`, a parameterised width/limit counter.
  - Controls: clear, enable, saturate-vs-wrap select.
  - Instantiated twice: wrap mode for `count`, saturate-at-limit mode for `timer`.
- Top level holds the FSM and the output registers.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `start`=1 → `count`=0, `timer`=0, immediately and with no dependence on a clock edge.
- Basic run: release reset, then `start`=1 continuously → after 7 edges from E0, `count`=7 and `timer`=7.
- Wrap and terminal: `start`=1 for 25 edges → `count` passes 15→0 at E0+16. At E0+20, `timer`=20 and `count`=4, and both stay frozen through E0+25.
- Pause: in RUN at `timer`=5, drop `start` for 3 cycles → outputs hold at 5. Raise `start` → next edge gives `timer`=6.
- Mid-run reset: at E0+7, assert `reset` low for 1 cycle with `start` held high → outputs go 0 asynchronously. First edge after release clears/enters RUN (outputs 0). The next edge gives 1, and outputs reach 20 / 4 at E0'+20.
- Re-arm: from DONE, drop `start` for 1 edge → IDLE with outputs holding 4/20. Raise `start` → outputs clear to 0 and a new run starts.

Source files
------------

// File: rtl/contador_buffer_pkg.sv
// contador_buffer_pkg: shared state encoding and default sizing for contador_buffer.
package contador_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cb_state_t;

    localparam int unsigned CB_COUNT_W     = 4;
    localparam int unsigned CB_TIMER_W     = 5;
    localparam int unsigned CB_TIMER_LIMIT = 20;

endpackage

// File: rtl/cb_up_counter.sv
// cb_up_counter: next-value logic for a clearable, enabled up counter.
// The register itself lives in the instantiating block.
//   value      : current registered value
//   clear      : force next value to zero (highest priority)
//   enable     : advance by one
//   next_c     : combinational next value
// SATURATE=1 holds the value once it reaches LIMIT; SATURATE=0 wraps modulo 2^W.
module cb_up_counter
    import contador_buffer_pkg::*;
#(
    parameter int unsigned W        = CB_COUNT_W,
    parameter int unsigned LIMIT    = (1 << W) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [W-1:0] value,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] next_c
);

    always_comb begin
        next_c = value;
        if (clear) begin
            next_c = '0;
        end else if (enable) begin
            if (SATURATE && (value >= W'(LIMIT))) begin
                next_c = value;
            end else begin
                next_c = value + W'(1);
            end
        end
    end

endmodule

// File: rtl/contador_buffer.sv
// contador_buffer: start-triggered cycle counter with a bounded run timer.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears state and outputs
//   start : level run request; pauses counting while low in RUN
//   count : registered cycle count, wraps modulo 2^COUNT_W
//   timer : registered run timer, stops at TIMER_LIMIT
module contador_buffer
    import contador_buffer_pkg::*;
#(
    parameter int unsigned COUNT_W     = CB_COUNT_W,
    parameter int unsigned TIMER_W     = CB_TIMER_W,
    parameter int unsigned TIMER_LIMIT = CB_TIMER_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [COUNT_W-1:0] count,
    output logic [TIMER_W-1:0] timer
);

    cb_state_t          state;
    cb_state_t          state_n;
    logic               clr_c;
    logic               en_c;
    logic [COUNT_W-1:0] count_next_c;
    logic [TIMER_W-1:0] timer_next_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and counter controls; the terminal check looks at the
    // current timer so the decision does not depend on the counter outputs.
    always_comb begin
        state_n = state;
        clr_c   = 1'b0;
        en_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    clr_c   = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    en_c = 1'b1;
                    if (timer == TIMER_W'(TIMER_LIMIT - 1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    cb_up_counter #(
        .W        (COUNT_W),
        .LIMIT    ((1 << COUNT_W) - 1),
        .SATURATE (1'b0)
    ) u_count (
        .value  (count),
        .clear  (clr_c),
        .enable (en_c),
        .next_c (count_next_c)
    );

    cb_up_counter #(
        .W        (TIMER_W),
        .LIMIT    (TIMER_LIMIT),
        .SATURATE (1'b1)
    ) u_timer (
        .value  (timer),
        .clear  (clr_c),
        .enable (en_c),
        .next_c (timer_next_c)
    );

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            timer <= '0;
        end else begin
            count <= count_next_c;
            timer <= timer_next_c;
        end
    end

endmodule

// File: tb/tb_contador_buffer.sv
// tb_contador_buffer: table-driven and randomized checks for contador_buffer.
module tb_contador_buffer;
    import contador_buffer_pkg::*;

    localparam int unsigned CW  = CB_COUNT_W;
    localparam int unsigned TW  = CB_TIMER_W;
    localparam int          LIM = int'(CB_TIMER_LIMIT);

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;

    int tests = 0;
    int fails = 0;

    // Reference: a run is "n cycles counted since the clearing edge"; count is
    // n mod 16, timer is n, and counting stops once n reaches the limit.
    bit m_active = 1'b0;
    int m_n      = 0;

    typedef struct {
        bit start;
        int exp_count;
        int exp_timer;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    contador_buffer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .timer (timer)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_edge(input bit s);
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_n      = 0;
            end
        end else if (m_n == LIM) begin
            if (!s) m_active = 1'b0;
        end else if (s) begin
            m_n++;
        end
    endtask

    task automatic step(input bit s);
        start = s;
        @(posedge clk);
        #1;
        if (reset) model_edge(s);
    endtask

    task automatic check_model(input string nm);
        check({nm, "_count"}, int'(count), m_n % 16);
        check({nm, "_timer"}, int'(timer), m_n);
    endtask

    // Drop reset between edges and confirm the outputs clear without a clock.
    task automatic assert_reset(input string nm);
        reset    = 1'b0;
        m_active = 1'b0;
        m_n      = 0;
        #2;
        check({nm, "_async_count"}, int'(count), 0);
        check({nm, "_async_timer"}, int'(timer), 0);
    endtask

    initial begin
        // Reset asserted before any clock edge, held two cycles with start high
        start = 1'b1;
        #1;
        assert_reset("rst0");
        step(1'b1);
        step(1'b1);
        check("rst_hold_count", int'(count), 0);
        check("rst_hold_timer", int'(timer), 0);
        reset = 1'b1;

        // Directed table: run to terminal through the wrap, then re-arm
        for (int i = 0; i <= 25; i++) begin
            vecs.push_back('{1'b1, (i < LIM ? i : LIM) % 16, (i < LIM ? i : LIM)});
        end
        vecs.push_back('{1'b0, 4, 20});
        vecs.push_back('{1'b0, 4, 20});
        vecs.push_back('{1'b1, 0, 0});
        vecs.push_back('{1'b1, 1, 1});

        foreach (vecs[i]) begin
            step(vecs[i].start);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_timer", i), int'(timer), vecs[i].exp_timer);
        end

        // Pause at timer=5 for three cycles, then resume
        for (int i = 0; i < 4; i++) step(1'b1);
        check("pause_pre_timer", int'(timer), 5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check($sformatf("pause%0d_timer", i), int'(timer), 5);
            check($sformatf("pause%0d_count", i), int'(count), 5);
        end
        step(1'b1);
        check("resume_timer", int'(timer), 6);
        check("resume_count", int'(count), 6);

        // Mid-run reset with start held high
        assert_reset("pre_run");
        reset = 1'b1;
        for (int i = 0; i <= 7; i++) step(1'b1);
        check("midrun_e7_timer", int'(timer), 7);
        assert_reset("midrun");
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        check("midrun_e0_count", int'(count), 0);
        check("midrun_e0_timer", int'(timer), 0);
        step(1'b1);
        check("midrun_e1_timer", int'(timer), 1);
        for (int i = 2; i <= 20; i++) step(1'b1);
        check("midrun_term_count", int'(count), 4);
        check("midrun_term_timer", int'(timer), 20);

        // Randomized start pattern with occasional reset pulses
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset("rand_rst");
                step(1'($urandom_range(0, 1)));
                reset = 1'b1;
            end else begin
                step($urandom_range(0, 99) < 75);
                check_model($sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
